// File: rtl/bp_cfg_boot_sequencer.sv
// bp_cfg_boot_sequencer: config-link initiator that freezes, configures, unfreezes and verifies every core
module bp_cfg_boot_sequencer #(
  parameter int num_core_p = 1,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int num_cce_instr_p = 256,
  parameter logic [cfg_data_width_p-1:0] boot_npc_p = 'h8000_0000,
  parameter int icache_mode_p = 1,
  parameter int dcache_mode_p = 1,
  parameter int cce_mode_p = 1,
  localparam int uw = num_cce_instr_p > 1 ? $clog2(num_cce_instr_p) : 1,
  localparam int cw = num_core_p > 1 ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic [uw-1:0]               ucode_addr_o,
  input  logic [cfg_data_width_p-1:0] ucode_data_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic                        cfg_w_o,
  output logic [cw-1:0]               cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_resp_v_i,
  input  logic [cfg_data_width_p-1:0] cfg_resp_data_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o
);
  localparam int aw = cfg_addr_width_p;
  localparam int dw = cfg_data_width_p;
  localparam logic [uw-1:0] last_i = uw'(num_cce_instr_p - 1);
  localparam logic [cw-1:0] last_core = cw'(num_core_p - 1);
  typedef enum logic [3:0] {
    IDLE, FREEZE, ICMODE, DCMODE, NPC, CCEMODE, UCODE, UNFREEZE, RD_REQ, RD_WAIT, DONE, ERROR
  } state_t;
  state_t state;
  logic [cw-1:0] core;
  logic [uw-1:0] ucode_i;
  logic hs;
  assign hs = cfg_v_o & cfg_ready_i;
  assign cfg_v_o = state inside {FREEZE, ICMODE, DCMODE, NPC, CCEMODE, UCODE, UNFREEZE, RD_REQ};
  assign cfg_w_o = state != RD_REQ;
  assign cfg_core_o = core;
  assign ucode_addr_o = ucode_i;
  // request address and payload are a pure function of the registered state and counters, so they hold through stalls
  always_comb begin
    cfg_addr_o = state == ICMODE  ? aw'(16'h0022)
               : state == DCMODE  ? aw'(16'h0042)
               : state == NPC     ? aw'(16'h0040)
               : state == CCEMODE ? aw'(16'h0081)
               : state == UCODE   ? aw'(32'h8000 + 32'(ucode_i))
               : aw'(16'h0002);
    cfg_data_o = state == FREEZE  ? dw'(1)
               : state == ICMODE  ? dw'(icache_mode_p)
               : state == DCMODE  ? dw'(dcache_mode_p)
               : state == NPC     ? boot_npc_p
               : state == CCEMODE ? dw'(cce_mode_p)
               : state == UCODE   ? ucode_data_i
               : '0;
  end
  // sequencer: per-core configure pass, unfreeze sweep, then freeze-register readback
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      core <= '0;
      ucode_i <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state <= FREEZE;
          core <= '0;
          busy_o <= 1'b1;
        end
        FREEZE: if (hs) state <= ICMODE;
        ICMODE: if (hs) state <= DCMODE;
        DCMODE: if (hs) state <= NPC;
        NPC: if (hs) state <= CCEMODE;
        CCEMODE: if (hs) state <= UCODE;
        UCODE: if (hs) begin
          if (ucode_i == last_i) begin
            ucode_i <= '0;
            core <= core == last_core ? '0 : core + 1'b1;
            state <= core == last_core ? UNFREEZE : FREEZE;
          end else ucode_i <= ucode_i + 1'b1;
        end
        UNFREEZE: if (hs) begin
          core <= core == last_core ? '0 : core + 1'b1;
          state <= core == last_core ? RD_REQ : UNFREEZE;
        end
        RD_REQ: if (hs) state <= RD_WAIT;
        RD_WAIT: if (cfg_resp_v_i) begin
          if (cfg_resp_data_i != '0) begin
            error_o <= 1'b1;
            busy_o <= 1'b0;
            state <= ERROR;
          end else if (core == last_core) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state <= DONE;
          end else begin
            core <= core + 1'b1;
            state <= RD_REQ;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// tb_bp_cfg_boot_sequencer: scoreboard bench for the config boot sequencer in two configurations
module tb_bp_cfg_boot_sequencer;
  typedef struct packed {
    logic        w;
    logic [7:0]  core;
    logic [15:0] addr;
    logic [63:0] data;
  } txn_t;
  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } reg_t;
  typedef struct {
    bit rnd;
    int err_core;
    bit spur;
    bit mid_start;
    bit exp_done;
  } scn_t;

  logic clk = 0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  reg_t cfg_tbl[5];
  scn_t scn_tbl[4];
  txn_t q_a[$];
  txn_t q_b[$];

  bit rand_ready = 0;
  bit spurious = 0;
  int err_core = -1;
  bit pend_a = 0;
  bit pend_b = 0;
  int rd_core_a = 0;

  logic rst_a = 1, start_a = 0, ready_a = 1, resp_v_a = 0;
  logic [63:0] resp_data_a = '0;
  logic [1:0] ucode_addr_a;
  logic [63:0] ucode_data_a, data_a;
  logic v_a, w_a, busy_a, done_a, err_a;
  logic [0:0] core_a;
  logic [15:0] addr_a;

  logic rst_b = 1, start_b = 0, resp_v_b = 0;
  logic [63:0] resp_data_b = '0;
  logic [0:0] ucode_addr_b;
  logic [63:0] ucode_data_b, data_b;
  logic v_b, w_b, busy_b, done_b, err_b;
  logic [0:0] core_b;
  logic [15:0] addr_b;

  function automatic logic [63:0] rom(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h1_0001;
  endfunction

  assign ucode_data_a = rom(int'(ucode_addr_a));
  assign ucode_data_b = rom(int'(ucode_addr_b));

  bp_cfg_boot_sequencer #(.num_core_p(2), .num_cce_instr_p(4)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .start_i(start_a),
    .ucode_addr_o(ucode_addr_a), .ucode_data_i(ucode_data_a),
    .cfg_v_o(v_a), .cfg_ready_i(ready_a), .cfg_w_o(w_a), .cfg_core_o(core_a),
    .cfg_addr_o(addr_a), .cfg_data_o(data_a),
    .cfg_resp_v_i(resp_v_a), .cfg_resp_data_i(resp_data_a),
    .busy_o(busy_a), .done_o(done_a), .error_o(err_a)
  );

  bp_cfg_boot_sequencer #(.num_core_p(1), .num_cce_instr_p(1)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .start_i(start_b),
    .ucode_addr_o(ucode_addr_b), .ucode_data_i(ucode_data_b),
    .cfg_v_o(v_b), .cfg_ready_i(1'b1), .cfg_w_o(w_b), .cfg_core_o(core_b),
    .cfg_addr_o(addr_b), .cfg_data_o(data_b),
    .cfg_resp_v_i(resp_v_b), .cfg_resp_data_i(resp_data_b),
    .busy_o(busy_b), .done_o(done_b), .error_o(err_b)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit which, input txn_t t);
    if (which) q_b.push_back(t);
    else q_a.push_back(t);
  endtask

  task automatic push_seq(input bit which, input int nc, input int ni, input int e);
    for (int c = 0; c < nc; c++) begin
      for (int r = 0; r < 5; r++) push(which, {1'b1, 8'(c), cfg_tbl[r].addr, cfg_tbl[r].data});
      for (int i = 0; i < ni; i++) push(which, {1'b1, 8'(c), 16'(32'h8000 + i), rom(i)});
    end
    for (int c = 0; c < nc; c++) push(which, {1'b1, 8'(c), 16'h0002, 64'h0});
    for (int c = 0; c <= (e < 0 ? nc - 1 : e); c++) push(which, {1'b0, 8'(c), 16'h0002, 64'h0});
  endtask

  // monitor A: scoreboard pop on every handshake and hold check on every stall
  initial begin
    txn_t act, held;
    bit stall;
    stall = 0;
    held = '0;
    forever begin
      @(negedge clk);
      act = {w_a, 8'(core_a), addr_a, data_a};
      if (rst_a) begin
        stall = 0;
        pend_a = 0;
      end else begin
        if (stall) chk("stall_hold", 128'({v_a, act}), 128'({1'b1, held}));
        if (v_a && ready_a) begin
          if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_req_a: unexpected request %0h", act);
          end else chk("txn_a", 128'(act), 128'(q_a.pop_front()));
          if (!w_a) begin
            pend_a = 1;
            rd_core_a = int'(core_a);
          end
        end
        stall = v_a && !ready_a;
        held = act;
      end
    end
  end

  // driver A: ready pattern, read responses one cycle after the read handshake, optional spurious response
  initial forever begin
    @(posedge clk);
    #1;
    ready_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    resp_v_a = pend_a || (spurious && ucode_addr_a == 2'd1);
    resp_data_a = pend_a ? (rd_core_a == err_core ? 64'h1 : 64'h0) : 64'hDEAD;
    pend_a = 0;
  end

  // monitor B: scoreboard pop on every handshake
  initial forever begin
    txn_t act;
    @(negedge clk);
    act = {w_b, 8'(core_b), addr_b, data_b};
    if (rst_b) pend_b = 0;
    else if (v_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_req_b: unexpected request %0h", act);
      end else chk("txn_b", 128'(act), 128'(q_b.pop_front()));
      if (!w_b) pend_b = 1;
    end
  end

  // driver B: zero readback one cycle after the read handshake
  initial forever begin
    @(posedge clk);
    #1;
    resp_v_b = pend_b;
    resp_data_b = '0;
    pend_b = 0;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit which);
    if (which) start_b = 1;
    else start_a = 1;
    cyc();
    start_a = 0;
    start_b = 0;
    cyc();
  endtask

  task automatic reset_a();
    rst_a = 1;
    cyc();
    cyc();
    rst_a = 0;
    chk("reset_state_a", 128'({v_a, busy_a, done_a, err_a, ucode_addr_a}), 128'(0));
  endtask

  task automatic wait_end(input bit which);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (which ? (done_b || err_b) : (done_a || err_a)) break;
    end
    chk("finished", 128'(which ? (done_b | err_b) : (done_a | err_a)), 128'(1));
  endtask

  task automatic run_scn(input scn_t s);
    rand_ready = s.rnd;
    err_core = s.err_core;
    spurious = s.spur;
    reset_a();
    q_a.delete();
    push_seq(0, 2, 4, s.err_core);
    pulse_start(0);
    if (s.mid_start) begin
      repeat (5) cyc();
      pulse_start(0);
    end
    wait_end(0);
    repeat (5) cyc();
    pulse_start(0);
    repeat (10) cyc();
    chk("q_empty_a", 128'(q_a.size()), 128'(0));
    chk("done_a", 128'(done_a), 128'(s.exp_done));
    chk("error_a", 128'(err_a), 128'(!s.exp_done));
    chk("idle_a", 128'({busy_a, v_a}), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_tbl[0] = '{16'h0002, 64'h1};
    cfg_tbl[1] = '{16'h0022, 64'h1};
    cfg_tbl[2] = '{16'h0042, 64'h1};
    cfg_tbl[3] = '{16'h0040, 64'h8000_0000};
    cfg_tbl[4] = '{16'h0081, 64'h1};
    scn_tbl[0] = '{0, -1, 0, 0, 1};
    scn_tbl[1] = '{1, -1, 1, 1, 1};
    scn_tbl[2] = '{0, 1, 0, 0, 0};
    scn_tbl[3] = '{1, 0, 0, 1, 0};
    for (int k = 0; k < 4; k++) run_scn(scn_tbl[k]);
    rand_ready = 0;
    err_core = -1;
    spurious = 0;
    reset_a();
    q_a.delete();
    push_seq(0, 2, 4, -1);
    pulse_start(0);
    for (int n = 0; n < 100; n++) begin
      if (ucode_addr_a == 2'd2 && core_a == 1'b0) break;
      cyc();
    end
    chk("reach_ucode2", 128'({ucode_addr_a, core_a}), 128'({2'd2, 1'b0}));
    rst_a = 1;
    cyc();
    rst_a = 0;
    chk("abort_idle", 128'({v_a, busy_a, done_a, err_a, ucode_addr_a}), 128'(0));
    repeat (3) cyc();
    chk("abort_quiet", 128'({v_a, busy_a}), 128'(0));
    q_a.delete();
    push_seq(0, 2, 4, -1);
    start_a = 1;
    cyc();
    start_a = 0;
    chk("restart_first", 128'({v_a, w_a, core_a, addr_a, data_a}), 128'({1'b1, 1'b1, 1'b0, 16'h0002, 64'h1}));
    chk("restart_busy", 128'(busy_a), 128'(1));
    wait_end(0);
    cyc();
    chk("restart_done", 128'({done_a, err_a, q_a.size() == 0}), 128'({1'b1, 1'b0, 1'b1}));
    rst_b = 1;
    cyc();
    cyc();
    rst_b = 0;
    chk("reset_state_b", 128'({v_b, busy_b, done_b, err_b, ucode_addr_b}), 128'(0));
    q_b.delete();
    push_seq(1, 1, 1, -1);
    pulse_start(1);
    wait_end(1);
    repeat (5) cyc();
    chk("q_empty_b", 128'(q_b.size()), 128'(0));
    chk("done_b", 128'({done_b, err_b, busy_b, v_b}), 128'({1'b1, 1'b0, 1'b0, 1'b0}));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bp_cfg_boot_sequencer.md
Name: bp_cfg_boot_sequencer

Overview:
Config-link initiator that brings the tile array out of reset. On a start pulse it issues an ordered series of config writes per core: freeze, cache modes, boot PC, CCE mode, and CCE microcode. It then unfreezes every core and reads back each freeze register to confirm. It sits between the host/boot ROM side and the per-tile config responders, driving the config-link request channel and consuming its read responses.

Parameters:
num_core_p, 1, number of cores to configure (core index 0..num_core_p-1)
cfg_addr_width_p, 16, config register address width
cfg_data_width_p, 64, config data width
num_cce_instr_p, 256, microcode words loaded per CCE
boot_npc_p, 'h8000_0000, boot PC written to every core
icache_mode_p, 1, value written to icache mode register
dcache_mode_p, 1, value written to dcache mode register
cce_mode_p, 1, value written to CCE mode register

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
start_i  in  1  one-cycle pulse; ignored unless idle
ucode_addr_o  out  log2(num_cce_instr_p)  microcode ROM index
ucode_data_i  in  cfg_data_width_p  ROM word for ucode_addr_o, combinational
cfg_v_o  out  1  request valid
cfg_ready_i  in  1  responder accepts request
cfg_w_o  out  1  1=write, 0=read
cfg_core_o  out  log2(max(2,num_core_p))  target core
cfg_addr_o  out  cfg_addr_width_p  register address
cfg_data_o  out  cfg_data_width_p  write data (0 on reads)
cfg_resp_v_i  in  1  read response valid
cfg_resp_data_i  in  cfg_data_width_p  read response data
busy_o  out  1  sequence in progress
done_o  out  1  sticky; sequence completed and verified
error_o  out  1  sticky; readback mismatch

Behaviour:
- Reset: state IDLE. cfg_v_o, busy_o, done_o, error_o = 0. Core and ucode counters = 0. Reset mid-sequence aborts immediately with no further requests. An in-flight response after reset is ignored.
- Handshake: a request completes on a cycle with cfg_v_o & cfg_ready_i. While cfg_v_o=1 and ready=0, all cfg_* outputs are held stable. There is at most one request per cycle. Back-to-back requests are allowed, so full ready gives 1 request/cycle.
- Register addresses and write data:
  - FREEZE: 0x0002, data 1
  - ICMODE: 0x0022, data icache_mode_p
  - DCMODE: 0x0042, data dcache_mode_p
  - NPC: 0x0040, data boot_npc_p
  - CCEMODE: 0x0081, data cce_mode_p
  - UCODE: 0x8000+i, data ucode_data_i, with ucode_addr_o=i
  - UNFREEZE: 0x0002, data 0
- FSM; each state advances on handshake unless noted:
  - IDLE: start_i -> FREEZE with core=0, busy_o=1. start_i is ignored in any other state and after done/error until reset.
  - Configure pass, per core: FREEZE -> ICMODE -> DCMODE -> NPC -> CCEMODE -> UCODE.
  - UCODE: i increments per handshake. At i=num_cce_instr_p-1 it resets i=0. If core<num_core_p-1, core++ and go to FREEZE; else core=0 and go to UNFREEZE.
  - UNFREEZE: write to each core in turn. After the last core, core=0 and go to RD_REQ.
  - RD_REQ: read (cfg_w_o=0) of 0x0002 for the current core -> RD_WAIT.
  - RD_WAIT: cfg_v_o=0 until cfg_resp_v_i.
    - Data != 0: error_o=1, busy_o=0 -> ERROR.
    - Data == 0 and more cores: core++ -> RD_REQ.
    - Data == 0 and last core: done_o=1, busy_o=0 -> DONE.
  - DONE and ERROR are terminal until reset.
- cfg_resp_v_i outside RD_WAIT is ignored.
- ucode_addr_o equals counter i in all states (0 outside UCODE).
- Exact request count: num_core_p*(5+num_cce_instr_p) writes, then num_core_p writes, then num_core_p reads.
- Counters size exactly to their ranges; num_core_p=1 and num_cce_instr_p=1 must work, with a 1-bit min width.

Test Plan:
- num_core_p=2, num_cce_instr_p=4, ready tied 1, responses return 0 one cycle after the read handshake -> 18 config writes in order, 2 unfreeze writes, 2 reads. Core 0 UCODE addresses are 0x8000..0x8003 with ROM data; done_o=1, error_o=0.
- Same config with ready toggling pseudo-randomly -> cfg_* outputs stable through every stall. The transaction sequence is identical to the first test.
- Core 1 readback returns 0x1 -> error_o=1, done_o=0, no further requests, busy_o=0.
- Assert reset_i during core 0 UCODE at i=2 -> next cycle cfg_v_o=0 and state IDLE. A new start_i restarts at FREEZE for core 0 with address 0x0002 and data 1.
- start_i pulsed during the sequence and again after done -> no effect. A spurious cfg_resp_v_i during UCODE -> ignored.
- num_core_p=1, num_cce_instr_p=1 -> exactly 6 writes, 1 unfreeze write and 1 read, then done_o=1.
